maze_path_stepper: RTL
======================

MAZE_PATH_STEPPER -- requirements
Module: maze_path_stepper

Interface
REQ-001 SHALL have parameter MAX_STEPS, default 99: the step limit per run.
REQ-002 SHALL have parameter BFS_TIMEOUT, default 4095: the maximum number of cycles spent waiting for bfs_done, used only when the timeout feature is compiled in.
REQ-003 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- go  in  1  run request.
- start_x, start_y  in  4 each  start cell.
- goal_x, goal_y  in  4 each  goal cell.
- goal_x_o, goal_y_o  out  4 each  goal cell driven to the BFS engine.
- curr_x, curr_y  out  4 each  current cell, driven to the BFS engine.
- bfs_start  out  1  single-cycle launch pulse to the BFS engine.
- bfs_done  in  1  BFS complete (level).
- bfs_dist  in  7  distance from curr to goal; 127 means unreachable.
- bfs_next_dir  in  2  N=00, E=01, S=10, W=11.
- bfs_next_valid  in  1  bfs_next_dir is meaningful.
- step_valid  out  1  a move is offered to the motion unit.
- step_dir  out  2  direction of the offered move.
- step_ready  in  1  the motion unit accepts the move.
- busy  out  1  a run is in progress.
- arrived  out  1  the run ended at the goal (sticky).
- fail_code  out  3  0 NONE, 1 NO_PATH, 2 BOUNDS, 3 STEP_LIMIT, 4 TIMEOUT (sticky).
- step_count  out  7  steps completed in the current run.

Function
REQ-004 SHALL implement the states IDLE, CHECK, LAUNCH, WAIT, EVAL, ISSUE, DONE and FAIL.
REQ-005 In IDLE, DONE or FAIL, go=1 SHALL do all of the following on the next edge:
- load curr from start_x/start_y;
- latch goal_x/goal_y into goal_x_o/goal_y_o;
- clear step_count, arrived and fail_code;
- enter CHECK.
REQ-006 go SHALL be ignored while busy.
REQ-007 In CHECK, the block SHALL enter DONE if curr equals the goal, and SHALL enter LAUNCH otherwise.
REQ-008 The start==goal case SHALL therefore never assert bfs_start.
REQ-009 In LAUNCH, bfs_start SHALL be 1 for exactly one cycle, followed by WAIT.
REQ-010 In WAIT, bfs_done SHALL be accepted only after it has been sampled low at least once since the launch (stale-done protection).
REQ-011 Once bfs_done is accepted, the block SHALL enter EVAL.
REQ-012 In EVAL, the checks SHALL be applied in priority order:
- bfs_dist==127 or bfs_next_valid==0 gives FAIL with code NO_PATH;
- step_count==MAX_STEPS gives FAIL with code STEP_LIMIT;
- a target cell outside 0..9 on either axis gives FAIL with code BOUNDS;
- otherwise the block enters ISSUE with step_dir latched from bfs_next_dir.
REQ-013 Target cell moves SHALL be: N is y-1, E is x+1, S is y+1, W is x-1, using 4-bit arithmetic.
REQ-014 Underflow from 0 or a result of 10 or more SHALL be treated as out of bounds.
REQ-015 In ISSUE, step_valid SHALL be 1, and step_dir SHALL remain stable until the handshake cycle where step_valid and step_ready are both 1.
REQ-016 In the handshake cycle, the block SHALL update curr to the target cell, increment step_count, drop step_valid on the next cycle and enter CHECK.
REQ-017 step_valid SHALL never be asserted outside ISSUE.
REQ-018 DONE SHALL set arrived=1; FAIL SHALL set fail_code. Both SHALL hold until the next accepted go or rst.
REQ-019 busy SHALL be 1 in every state except IDLE, DONE and FAIL.
REQ-020 From IDLE, the latency from go to the first bfs_start SHALL be 2 cycles.

Reset
REQ-021 While rst=1 at a clock edge, the block SHALL reset to:
- state IDLE;
- curr_x, curr_y, goal_x_o, goal_y_o = 0;
- bfs_start, step_valid, busy, arrived = 0;
- step_dir = 00, fail_code = 0, step_count = 0;
- WAIT timer cleared.
REQ-022 rst asserted mid-run, including in ISSUE, SHALL abandon the run with no further handshake.

Configuration
REQ-023 The macro MAZE_STEPPER_TIMEOUT_EN SHALL control the WAIT timeout.
REQ-024 With the macro defined, a counter SHALL run in WAIT. If BFS_TIMEOUT cycles elapse without an accepted bfs_done, the block SHALL enter FAIL with code TIMEOUT.
REQ-025 Without the macro, the block SHALL wait indefinitely, include no counter logic, and never produce code 4.

Structure
REQ-026 A shared package maze_pkg SHALL hold:
- the direction enum (N/E/S/W);
- the fail_code enum;
- the state enum;
- GRID_DIM=10;
- DIST_INF=7'h7F.
REQ-027 The move-and-bounds arithmetic SHALL be one combinational sub-module, maze_step_calc: inputs x, y, dir; outputs nx, ny, oob.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Open 10x10 grid with a BFS model, start (0,0), goal (9,9), step_ready always 1: arrived=1, step_count=18, final curr=(9,9), fail_code=0.
- Start (3,3), goal (3,3): arrived=1 within 2 cycles of go, bfs_start never asserted, step_count=0.
- Model returns bfs_dist=127: FAIL with fail_code=1, step_valid never asserted, busy=0.
- step_ready held 0 for 5 cycles in ISSUE: step_valid=1 and step_dir unchanged for all 5 cycles; curr updates only on the handshake cycle.
- Macro defined, BFS_TIMEOUT=16, bfs_done held 0: fail_code=4 after 16 WAIT cycles. Macro undefined: still busy after 1000 cycles.
- bfs_done stuck at 1 across a launch: no EVAL until a low-then-high transition occurs. rst asserted in ISSUE: all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/maze_pkg.sv
// maze_pkg: shared grid constants and direction, fail-code and state encodings for the maze stepper
package maze_pkg;
  localparam int GRID_DIM = 10;
  localparam logic [6:0] DIST_INF = 7'h7F;
  typedef enum logic [1:0] {DIR_N, DIR_E, DIR_S, DIR_W} dir_e;
  typedef enum logic [2:0] {FC_NONE, FC_NO_PATH, FC_BOUNDS, FC_STEP_LIMIT, FC_TIMEOUT} fail_e;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LAUNCH, S_WAIT, S_EVAL, S_ISSUE, S_DONE, S_FAIL} state_e;
endpackage

// File: rtl/maze_step_calc.sv
// maze_step_calc: one-cell move in 4-bit arithmetic; wrap below 0 lands at 15 and so reads as out of bounds
module maze_step_calc
  import maze_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  dir_e       dir,
  output logic [3:0] nx,
  output logic [3:0] ny,
  output logic       oob
);
  always_comb begin
    nx  = dir == DIR_E ? x + 4'd1 : dir == DIR_W ? x - 4'd1 : x;
    ny  = dir == DIR_S ? y + 4'd1 : dir == DIR_N ? y - 4'd1 : y;
    oob = nx >= 4'(GRID_DIM) || ny >= 4'(GRID_DIM);
  end
endmodule

// File: rtl/maze_path_stepper.sv
// maze_path_stepper: walks a cell toward the goal one BFS-advised move at a time.
// Define MAZE_STEPPER_TIMEOUT_EN to bound the wait for bfs_done by BFS_TIMEOUT cycles.
module maze_path_stepper
  import maze_pkg::*;
#(
  parameter int MAX_STEPS   = 99,
  parameter int BFS_TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [3:0] start_x,
  input  logic [3:0] start_y,
  input  logic [3:0] goal_x,
  input  logic [3:0] goal_y,
  output logic [3:0] goal_x_o,
  output logic [3:0] goal_y_o,
  output logic [3:0] curr_x,
  output logic [3:0] curr_y,
  output logic       bfs_start,
  input  logic       bfs_done,
  input  logic [6:0] bfs_dist,
  input  logic [1:0] bfs_next_dir,
  input  logic       bfs_next_valid,
  output logic       step_valid,
  output logic [1:0] step_dir,
  input  logic       step_ready,
  output logic       busy,
  output logic       arrived,
  output logic [2:0] fail_code,
  output logic [6:0] step_count
);
  state_e     r_state, w_next;
  fail_e      r_fail, w_fail;
  dir_e       r_dir, w_dir;
  logic [3:0] r_cx, r_cy, r_gx, r_gy, w_nx, w_ny;
  logic [6:0] r_count;
  logic       r_arrived, r_seen_low;
  logic       w_oob, w_busy, w_accept, w_at_goal, w_timeout;

  // During ISSUE the latched move drives the adder so the target stays stable under back-pressure
  assign w_dir = r_state == S_ISSUE ? r_dir : dir_e'(bfs_next_dir);

  maze_step_calc u_calc (
    .x  (r_cx),
    .y  (r_cy),
    .dir(w_dir),
    .nx (w_nx),
    .ny (w_ny),
    .oob(w_oob)
  );

  assign w_busy    = !(r_state inside {S_IDLE, S_DONE, S_FAIL});
  assign w_at_goal = r_cx == r_gx && r_cy == r_gy;
  assign w_accept  = r_state == S_WAIT && bfs_done && r_seen_low;

`ifdef MAZE_STEPPER_TIMEOUT_EN
  localparam int TW = $clog2(BFS_TIMEOUT + 1);
  logic [TW-1:0] r_timer;
  always_ff @(posedge clk) r_timer <= (rst || r_state != S_WAIT) ? '0 : r_timer + 1'b1;
  assign w_timeout = r_state == S_WAIT && r_timer == TW'(BFS_TIMEOUT - 1);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;

  always_comb begin
    w_next = r_state;
    w_fail = FC_NONE;
    case (r_state)
      S_IDLE, S_DONE, S_FAIL: w_next = go ? S_CHECK : r_state;
      S_CHECK:  w_next = w_at_goal ? S_DONE : S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        w_fail = !w_accept && w_timeout ? FC_TIMEOUT : FC_NONE;
        w_next = w_accept ? S_EVAL : w_timeout ? S_FAIL : S_WAIT;
      end
      S_EVAL: begin
        w_fail = (bfs_dist == DIST_INF || !bfs_next_valid) ? FC_NO_PATH :
                 r_count == 7'(MAX_STEPS) ? FC_STEP_LIMIT :
                 w_oob ? FC_BOUNDS : FC_NONE;
        w_next = w_fail == FC_NONE ? S_ISSUE : S_FAIL;
      end
      S_ISSUE:  w_next = step_ready ? S_CHECK : S_ISSUE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cx       <= '0;
      r_cy       <= '0;
      r_gx       <= '0;
      r_gy       <= '0;
      r_count    <= '0;
      r_dir      <= DIR_N;
      r_fail     <= FC_NONE;
      r_arrived  <= 1'b0;
      r_seen_low <= 1'b0;
    end else begin
      if (go && !w_busy) begin
        r_cx      <= start_x;
        r_cy      <= start_y;
        r_gx      <= goal_x;
        r_gy      <= goal_y;
        r_count   <= '0;
        r_arrived <= 1'b0;
        r_fail    <= FC_NONE;
      end
      if (r_state == S_CHECK && w_at_goal) r_arrived <= 1'b1;
      if (w_fail != FC_NONE) r_fail <= w_fail;
      if (r_state == S_EVAL) r_dir <= dir_e'(bfs_next_dir);
      // A done still high from the previous search must be seen low before it counts
      if (r_state == S_LAUNCH) r_seen_low <= !bfs_done;
      else if (r_state == S_WAIT && !bfs_done) r_seen_low <= 1'b1;
      if (r_state == S_ISSUE && step_ready) begin
        r_cx    <= w_nx;
        r_cy    <= w_ny;
        r_count <= r_count + 7'd1;
      end
    end
  end

  assign goal_x_o   = r_gx;
  assign goal_y_o   = r_gy;
  assign curr_x     = r_cx;
  assign curr_y     = r_cy;
  assign bfs_start  = r_state == S_LAUNCH;
  assign step_valid = r_state == S_ISSUE;
  assign step_dir   = r_dir;
  assign busy       = w_busy;
  assign arrived    = r_arrived;
  assign fail_code  = r_fail;
  assign step_count = r_count;
endmodule
